// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller: per-bit direction, atomic set/clear/toggle,
// synchronised inputs and per-bit edge interrupts with selectable polarity.
module gpio_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [3:0] A_OUT      = 4'd0;
  localparam logic [3:0] A_OUT_SET  = 4'd1;
  localparam logic [3:0] A_OUT_CLR  = 4'd2;
  localparam logic [3:0] A_OUT_TGL  = 4'd3;
  localparam logic [3:0] A_DIR      = 4'd4;
  localparam logic [3:0] A_IN       = 4'd5;
  localparam logic [3:0] A_IRQ_EN   = 4'd6;
  localparam logic [3:0] A_IRQ_STAT = 4'd7;
  localparam logic [3:0] A_IRQ_EDGE = 4'd8;

  logic [WIDTH-1:0] out_reg, out_next;
  logic [WIDTH-1:0] dir_reg, dir_next;
  logic [WIDTH-1:0] en_reg, en_next;
  logic [WIDTH-1:0] stat_reg, stat_next;
  logic [WIDTH-1:0] edge_reg, edge_next;
  logic [WIDTH-1:0] in_prev_reg;
  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic             irq_reg, irq_next;

  assign in_sync = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_reg[s] <= '0;
      in_prev_reg <= '0;
    end else begin
      sync_reg[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_reg[s] <= sync_reg[s-1];
      in_prev_reg <= in_sync;
    end
  end

  // Polarity is applied at detection time, so a pending edge uses the current IRQ_EDGE.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign ev[gi] = edge_reg[gi] ? (~in_sync[gi] & in_prev_reg[gi])
                                   : (in_sync[gi] & ~in_prev_reg[gi]);
    end
  endgenerate

  always_comb begin
    out_next  = out_reg;
    dir_next  = dir_reg;
    en_next   = en_reg;
    edge_next = edge_reg;
    clr       = '0;
    if (we) begin
      case (addr)
        A_OUT:      out_next  = wdata;
        A_OUT_SET:  out_next  = out_reg | wdata;
        A_OUT_CLR:  out_next  = out_reg & ~wdata;
        A_OUT_TGL:  out_next  = out_reg ^ wdata;
        A_DIR:      dir_next  = wdata;
        A_IRQ_EN:   en_next   = wdata;
        A_IRQ_STAT: clr       = wdata;
        A_IRQ_EDGE: edge_next = wdata;
        default:    ;
      endcase
    end
    // A fresh event outranks a simultaneous write-1-to-clear.
    stat_next = (stat_reg & ~clr) | ev;
    irq_next  = |(stat_reg & en_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= '0;
      dir_reg  <= '0;
      en_reg   <= '0;
      stat_reg <= '0;
      edge_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      out_reg  <= out_next;
      dir_reg  <= dir_next;
      en_reg   <= en_next;
      stat_reg <= stat_next;
      edge_reg <= edge_next;
      irq_reg  <= irq_next;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      A_OUT:      rdata = out_reg;
      A_DIR:      rdata = dir_reg;
      A_IN:       rdata = in_sync;
      A_IRQ_EN:   rdata = en_reg;
      A_IRQ_STAT: rdata = stat_reg;
      A_IRQ_EDGE: rdata = edge_reg;
      default:    rdata = '0;
    endcase
  end

  assign gpio_out = out_reg;
  assign gpio_oe  = dir_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register-map vectors from a table plus
// hand-written sequences for sync latency, polarity, W1C races, masking and reset.
module tb_gpio_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata;
  logic [7:0] gpio_in = 8'd0;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       irq;

  int total = 0;
  int bad = 0;

  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [3:0] rd_addr;
    logic [7:0] exp_rd;
    logic [7:0] exp_out;
    logic [7:0] exp_oe;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Write lands on the next rising edge; returns 1 ns after that edge.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    $display("write addr=%0d data=0x%02h", a, d);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;

    vecs[0] = '{4'd0, 8'hA5, 4'd0, 8'hA5, 8'hA5, 8'h00};
    vecs[1] = '{4'd1, 8'h0A, 4'd0, 8'hAF, 8'hAF, 8'h00};
    vecs[2] = '{4'd2, 8'h81, 4'd0, 8'h2E, 8'h2E, 8'h00};
    vecs[3] = '{4'd3, 8'hFF, 4'd0, 8'hD1, 8'hD1, 8'h00};
    vecs[4] = '{4'd4, 8'h3C, 4'd4, 8'h3C, 8'hD1, 8'h3C};
    vecs[5] = '{4'd5, 8'hFF, 4'd5, 8'h00, 8'hD1, 8'h3C};
    vecs[6] = '{4'd9, 8'hFF, 4'd9, 8'h00, 8'hD1, 8'h3C};
    vecs[7] = '{4'd1, 8'h00, 4'd1, 8'h00, 8'hD1, 8'h3C};
    vecs[8] = '{4'd8, 8'h5A, 4'd8, 8'h5A, 8'hD1, 8'h3C};
    vecs[9] = '{4'd8, 8'h00, 4'd8, 8'h00, 8'hD1, 8'h3C};

    // Reset state
    #2;
    chk("rst_out", gpio_out, 8'h00);
    chk("rst_oe", gpio_oe, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    edges(4);

    // Table-driven register map
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_out", i), gpio_out, vecs[i].exp_out);
      chk($sformatf("vec%0d_oe", i), gpio_oe, vecs[i].exp_oe);
      rd(vecs[i].rd_addr, v);
      chk($sformatf("vec%0d_rd", i), v, vecs[i].exp_rd);
    end

    // Sync latency on bit 3 with IRQ_EN[3]=1
    wr(4'd6, 8'h08);
    @(negedge clk); gpio_in[3] = 1'b1;
    edges(1);                              // edge k
    rd(4'd5, v); chk("sync_in_k", v, 8'h00);
    edges(1);                              // edge k+1
    rd(4'd5, v); chk("sync_in_k1", v, 8'h08);
    rd(4'd7, v); chk("sync_stat_k1", v, 8'h00);
    edges(1);                              // edge k+2
    rd(4'd7, v); chk("sync_stat_k2", v, 8'h08);
    chk("sync_irq_k2", {7'd0, irq}, 8'h00);
    edges(1);                              // edge k+3
    chk("sync_irq_k3", {7'd0, irq}, 8'h01);
    $display("sync latency sequence done");
    wr(4'd6, 8'h00);
    wr(4'd7, 8'hFF);
    edges(1);
    chk("sync_irq_off", {7'd0, irq}, 8'h00);

    // Polarity: bit0 falling, bit1 rising
    wr(4'd8, 8'h01);
    @(negedge clk); gpio_in[0] = 1'b1;
    edges(4);
    rd(4'd7, v); chk("pol_b0_rise", v, 8'h00);
    @(negedge clk); gpio_in[0] = 1'b0;
    edges(4);
    rd(4'd7, v); chk("pol_b0_fall", v, 8'h01);
    wr(4'd7, 8'h01);
    @(negedge clk); gpio_in[1] = 1'b1;
    edges(4);
    rd(4'd7, v); chk("pol_b1_rise", v, 8'h02);
    wr(4'd7, 8'h02);
    @(negedge clk); gpio_in[1] = 1'b0;
    edges(4);
    rd(4'd7, v); chk("pol_b1_fall", v, 8'h00);
    $display("polarity sequence done");

    // W1C racing a new rising event on bit1
    wr(4'd8, 8'h00);
    wr(4'd6, 8'h02);
    @(negedge clk); gpio_in[1:0] = 2'b11;
    edges(4);
    rd(4'd7, v); chk("w1c_pre", v, 8'h03);
    @(negedge clk); gpio_in[1] = 1'b0;
    edges(4);
    chk("w1c_irq_pre", {7'd0, irq}, 8'h01);
    @(negedge clk); gpio_in[1] = 1'b1;
    @(posedge clk);                        // edge k
    @(posedge clk);                        // edge k+1
    wr(4'd7, 8'h03);                       // clear on edge k+2, event lands there too
    rd(4'd7, v); chk("w1c_stat", v, 8'h02);
    chk("w1c_irq_k2", {7'd0, irq}, 8'h01);
    edges(1);
    chk("w1c_irq_k3", {7'd0, irq}, 8'h01);
    $display("w1c race sequence done");
    wr(4'd6, 8'h00);
    wr(4'd7, 8'hFF);

    // Masking
    @(negedge clk); gpio_in[4] = 1'b1;
    edges(4);
    rd(4'd7, v); chk("mask_stat", v, 8'h10);
    chk("mask_irq_off", {7'd0, irq}, 8'h00);
    wr(4'd6, 8'h10);
    chk("mask_irq_en0", {7'd0, irq}, 8'h00);
    edges(1);
    chk("mask_irq_en1", {7'd0, irq}, 8'h01);
    wr(4'd7, 8'h10);
    rd(4'd7, v); chk("mask_clr_stat", v, 8'h00);
    chk("mask_clr_irq0", {7'd0, irq}, 8'h01);
    edges(1);
    chk("mask_clr_irq1", {7'd0, irq}, 8'h00);
    $display("masking sequence done");

    // Asynchronous reset mid-run with irq asserted
    wr(4'd0, 8'hFF);
    wr(4'd4, 8'hFF);
    @(negedge clk); gpio_in = 8'h00;
    edges(4);
    @(negedge clk); gpio_in[4] = 1'b1;
    edges(5);
    chk("pre_rst_irq", {7'd0, irq}, 8'h01);
    chk("pre_rst_out", gpio_out, 8'hFF);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out", gpio_out, 8'h00);
    chk("arst_oe", gpio_oe, 8'h00);
    chk("arst_irq", {7'd0, irq}, 8'h00);
    gpio_in = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      rd(a[3:0], v);
      chk($sformatf("post_rst_rd%0d", a), v, 8'h00);
    end
    $display("reset sequence done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Parametrised, register-mapped GPIO controller; next generation of the team's single 8-bit output register.
- Adds per-bit direction, atomic set/clear/toggle writes and a synchronised input path.
- Adds per-bit edge-detect interrupts with selectable polarity.
- Sits on the core's simple peripheral bus: single-cycle write strobe, combinational read. Drives pad-level out/oe and takes raw pad inputs.

Parameters:
- WIDTH, 8: number of GPIO bits (1..32); all data registers are WIDTH bits.
- SYNC_STAGES, 2: flops in the input synchroniser (>=2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write strobe; one write per cycle it is high.
- addr  input  4  register select.
- wdata  input  WIDTH  write data.
- rdata  output  WIDTH  read data for addr; combinational, no read side effects.
- gpio_in  input  WIDTH  raw asynchronous pad inputs.
- gpio_out  output  WIDTH  output data register.
- gpio_oe  output  WIDTH  output enable; 1 = drive. Equals the DIR register.
- irq  output  1  level interrupt, registered.

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low.
- Reset state: every register, every synchroniser flop, in_prev and irq are 0. Hence gpio_out=0, gpio_oe=0, irq=0.
- Register map (addr : name : access):
  - 0 : OUT : RW
  - 1 : OUT_SET : W, OUT |= wdata
  - 2 : OUT_CLR : W, OUT &= ~wdata
  - 3 : OUT_TGL : W, OUT ^= wdata
  - 4 : DIR : RW
  - 5 : IN : RO, synchronised input
  - 6 : IRQ_EN : RW
  - 7 : IRQ_STAT : R, write-1-to-clear
  - 8 : IRQ_EDGE : RW, per bit 0=rising, 1=falling
- Reads of addr 1-3 and 9-15 return 0. Writes to 5 and 9-15 are ignored.
- Write latency: a register updates on the clk edge where we=1. gpio_out/gpio_oe reflect it in the same cycle's registered output, i.e. visible the cycle after the strobe.
- Input path: gpio_in passes through SYNC_STAGES flops to give in_sync. in_prev <= in_sync every cycle. IN reads in_sync.
- Edge detect, per bit i:
  - rising_i = in_sync[i] & ~in_prev[i]
  - falling_i = ~in_sync[i] & in_prev[i]
  - ev_i = IRQ_EDGE[i] ? falling_i : rising_i
- IRQ_STAT[i] next = (IRQ_STAT[i] & ~clr_i) | ev_i, where clr_i = we & (addr==7) & wdata[i].
  - A new event in the same cycle as a clear wins: the bit stays 1.
- Events set IRQ_STAT regardless of IRQ_EN. IRQ_EN gates only irq.
- irq <= |(IRQ_STAT & IRQ_EN), registered. It asserts one cycle after the status bit is visible.
- End-to-end latency: a pad change stable before clk edge k appears in in_sync after SYNC_STAGES edges. IRQ_STAT sets 1 edge later, and irq 1 edge after that.
- Pulses shorter than one clk period may be missed; this is accepted and not flagged.
- Post-reset: a pad held high when reset releases produces one rising event once the synchroniser fills. Firmware clears IRQ_STAT before setting IRQ_EN. IRQ_EN=0 at reset, so no spurious irq reaches the core.
- Changing IRQ_EDGE does not clear IRQ_STAT. An event pending in the pipeline is judged with the new polarity.
- Reset asserted mid-operation clears all state immediately, without waiting for clk. Pending events are lost.
- gpio_out is driven from OUT regardless of DIR. Pad gating by gpio_oe happens at the top level.
- Bits above WIDTH in wdata/rdata do not exist. For WIDTH=1 all register operations act on bit 0 only.

Test Plan:
- Reset: assert rst_n=0 mid-run with OUT=0xFF, DIR=0xFF -> gpio_out=0x00, gpio_oe=0x00, irq=0 asynchronously. Every register reads 0 after release.
- Atomic writes: OUT=0xA5, then SET 0x0A, CLR 0x81, TGL 0xFF -> reads 0xAF, 0x2E, 0xD1 successively. gpio_out matches one cycle after each strobe.
- Input sync latency (SYNC_STAGES=2): drive gpio_in[3] 0->1 before edge k:
  - IN[3]=1 after edge k+1;
  - IRQ_STAT[3]=1 after k+2;
  - with IRQ_EN[3]=1, irq=1 after k+3.
- Polarity: IRQ_EDGE=0x01. Bit0 rising gives no status, bit0 falling sets STAT bit0. Bit1 (rising mode) set by rising only.
- W1C vs new event: STAT=0x03, write 0x03 to addr 7 in the same cycle a new rising event on bit1 lands -> STAT=0x02, irq stays 1 if EN[1]=1.
- Masking: STAT=0x10 with IRQ_EN=0 gives irq=0. Write IRQ_EN=0x10 -> irq=1 next cycle. Clear STAT -> irq=0 one cycle after the status clears.
